seq_user_check: RTL and testbench

- Checks the player's reply in the Genius game after the FPGA has played the round sequence.
- Reads the expected colours from the sequence memory one index at a time and detects player button presses.
- Compares each press against the expected colour.
- Reports round success, a wrong colour or a timeout to the game controller.

---
 rtl/seq_pkg.sv | 25 ++
 rtl/press_detect.sv | 36 +++
 rtl/seq_user_check.sv | 150 +++++++++++++++
 tb/tb_seq_user_check.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared state encoding, colour codes and helpers for the player-reply checker.
package seq_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned SW    = 3;

  localparam logic [SW-1:0] S_IDLE         = 3'd0;
  localparam logic [SW-1:0] S_WAIT_PRESS   = 3'd1;
  localparam logic [SW-1:0] S_WAIT_RELEASE = 3'd2;
  localparam logic [SW-1:0] S_DONE         = 3'd3;
  localparam logic [SW-1:0] S_ERR          = 3'd4;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } colour_e;

  // True when exactly one bit of a 4-bit button vector is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/press_detect.sv
// Turns debounced button levels into single-cycle press events with a colour code.
module press_detect
  import seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  output logic       press_c,
  output logic [1:0] colour_c,
  output logic       released_c
);

  logic [3:0] btn_prev;

  // Previous button levels, so a press is only seen on the transition out of all-released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
    end else begin
      btn_prev <= btn;
    end
  end

  // Press qualification and colour decode; multi-hot patterns never qualify.
  always_comb begin
    press_c    = is_onehot4(btn) && (btn_prev == 4'd0);
    released_c = (btn == 4'd0);
    case (btn)
      4'b0010: colour_c = RED;
      4'b0100: colour_c = YELLOW;
      4'b1000: colour_c = BLUE;
      default: colour_c = GREEN;
    endcase
  end

endmodule

// File: rtl/seq_user_check.sv
// Checks the player's button sequence against the stored round and reports ok/error/timeout.
module seq_user_check
  import seq_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned TMO = 250000000
) (
  input  logic         clk_i,
  input  logic         r_i,
  input  logic         e_i,
  input  logic [N-1:0] round_i,
  input  logic [3:0]   btn_i,
  input  logic [1:0]   exp_i,
  output logic [N-1:0] addr_o,
  output logic [N:0]   sequsr_o,
  output logic         busy_o,
  output logic         ok_o,
  output logic         err_o,
  output logic         tmo_o
);

  localparam int unsigned TW  = $clog2(TMO);
  localparam int unsigned CW  = N + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

  logic [SW-1:0] state, state_d;
  logic          e_prev;
  logic [N-1:0]  round_q, round_d;
  logic [TW-1:0] timer, timer_d, timer_inc;
  logic [N-1:0]  addr_d;
  logic [CW-1:0] seq_d;
  logic          busy_d, ok_d, err_d, tmo_d;

  logic          press, released;
  logic [1:0]    colour;
  logic          match, last, timeout;

  press_detect u_press (
    .clk       (clk_i),
    .rst_n     (r_i),
    .btn       (btn_i),
    .press_c   (press),
    .colour_c  (colour),
    .released_c(released)
  );

  // State, counters, timer and registered response outputs.
  always_ff @(posedge clk_i or negedge r_i) begin
    if (!r_i) begin
      state    <= S_IDLE;
      e_prev   <= 1'b0;
      round_q  <= '0;
      timer    <= '0;
      addr_o   <= '0;
      sequsr_o <= '0;
      busy_o   <= 1'b0;
      ok_o     <= 1'b0;
      err_o    <= 1'b0;
      tmo_o    <= 1'b0;
    end else begin
      state    <= state_d;
      e_prev   <= e_i;
      round_q  <= round_d;
      timer    <= timer_d;
      addr_o   <= addr_d;
      sequsr_o <= seq_d;
      busy_o   <= busy_d;
      ok_o     <= ok_d;
      err_o    <= err_d;
      tmo_o    <= tmo_d;
    end
  end

  // Next-state and datapath decisions; press outranks timeout, abort outranks everything.
  always_comb begin
    state_d = state;
    round_d = round_q;
    timer_d = timer;
    addr_d  = addr_o;
    seq_d   = sequsr_o;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;

    timeout   = (timer == T_LAST);
    timer_inc = timeout ? timer : (timer + TW'(1));
    match     = (colour == exp_i);
    last      = (addr_o == round_q);

    case (state)
      S_IDLE: begin
        if (e_i && !e_prev) begin
          state_d = S_WAIT_PRESS;
          round_d = round_i;
          addr_d  = '0;
          seq_d   = '0;
          timer_d = '0;
        end
      end
      S_WAIT_PRESS: begin
        if (!e_i) begin
          state_d = S_IDLE;
        end else if (press && match && !last) begin
          addr_d  = addr_o + N'(1);
          seq_d   = sequsr_o + CW'(1);
          timer_d = '0;
          state_d = S_WAIT_RELEASE;
        end else if (press && match) begin
          seq_d   = sequsr_o + CW'(1);
          ok_d    = 1'b1;
          state_d = S_DONE;
        end else if (press) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (timeout) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_RELEASE: begin
        if (!e_i) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          timer_d = timer_inc;
          if (released) begin
            state_d = S_WAIT_PRESS;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (released && !e_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_WAIT_PRESS) || (state_d == S_WAIT_RELEASE);
  end

endmodule

// File: tb/tb_seq_user_check.sv
// Self-checking bench for seq_user_check: vector table, directed sequences, random rounds.
module tb_seq_user_check;

  localparam int TMO = 20;

  logic       clk_i;
  logic       r_i;
  logic       e_i;
  logic [3:0] round_i;
  logic [3:0] btn_i;
  logic [1:0] exp_i;
  logic [3:0] addr_o;
  logic [4:0] sequsr_o;
  logic       busy_o, ok_o, err_o, tmo_o;

  logic [1:0] mem [16];
  int         tr_round;
  int         tr_gap  [16];
  int         tr_hold [16];
  logic [1:0] tr_col  [16];

  int n_chk;
  int n_err;

  seq_user_check #(.N(4), .TMO(TMO)) dut (
    .clk_i   (clk_i),
    .r_i     (r_i),
    .e_i     (e_i),
    .round_i (round_i),
    .btn_i   (btn_i),
    .exp_i   (exp_i),
    .addr_o  (addr_o),
    .sequsr_o(sequsr_o),
    .busy_o  (busy_o),
    .ok_o    (ok_o),
    .err_o   (err_o),
    .tmo_o   (tmo_o)
  );

  // Sequence memory: combinational read at the DUT's current index.
  assign exp_i = mem[addr_o];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_out();
    btn_i = 4'd0;
    e_i   = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_entry(input int k, input logic [1:0] col, input int gap, input int hold);
    tr_col[k]  = col;
    tr_gap[k]  = gap;
    tr_hold[k] = hold;
  endtask

  // Model: each entry's press lands 'gap' edges after the previous accepted press (or start).
  // A gap beyond TMO times out exactly TMO edges after that reference point.
  task automatic run_trial(input string nm);
    int   prev, pos, exp_edge, kind, eseq, eaddr, stray, nbusy;
    bit   fin;
    logic [3:0] bt [512];
    for (int i = 0; i < 512; i++) bt[i] = 4'd0;
    prev = 0; fin = 1'b0; exp_edge = 0; kind = 0; eseq = 0; eaddr = 0;
    for (int k = 0; k <= tr_round; k++) begin
      if (!fin) begin
        if (tr_gap[k] > TMO) begin
          fin = 1'b1; kind = 2; exp_edge = prev + TMO; eseq = k; eaddr = k;
        end else begin
          pos = prev + tr_gap[k];
          for (int h = 0; h < tr_hold[k]; h++) bt[pos + h] = 4'b0001 << tr_col[k];
          if (tr_col[k] != mem[k]) begin
            fin = 1'b1; kind = 1; exp_edge = pos; eseq = k; eaddr = k;
          end else if (k == tr_round) begin
            fin = 1'b1; kind = 0; exp_edge = pos; eseq = k + 1; eaddr = k;
          end else begin
            prev = pos;
          end
        end
      end
    end

    round_i = 4'(tr_round);
    btn_i   = 4'd0;
    e_i     = 1'b1;
    tick();
    stray = 0;
    nbusy = 0;
    for (int t = 1; t <= exp_edge; t++) begin
      btn_i = bt[t];
      tick();
      if (t < exp_edge) begin
        if (ok_o || err_o || tmo_o) stray++;
        if (!busy_o) nbusy++;
      end
    end
    chk({nm, "_stray_pulse"}, stray, 0);
    chk({nm, "_busy_during"}, nbusy, 0);
    chk({nm, "_ok"}, int'(ok_o), (kind == 0) ? 1 : 0);
    chk({nm, "_err"}, int'(err_o), (kind != 0) ? 1 : 0);
    chk({nm, "_tmo"}, int'(tmo_o), (kind == 2) ? 1 : 0);
    chk({nm, "_sequsr"}, int'(sequsr_o), eseq);
    chk({nm, "_addr"}, int'(addr_o), eaddr);
    chk({nm, "_busy_after"}, int'(busy_o), 0);
    btn_i = 4'd0;
    e_i   = 1'b0;
    tick();
    chk({nm, "_pulse_width"}, int'(ok_o || err_o || tmo_o), 0);
    tick();
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [1:0] expc;
    logic       ok;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t vt [9];

  initial begin
    int base;
    n_chk = 0;
    n_err = 0;
    r_i = 1'b0; e_i = 1'b0; btn_i = 4'd0; round_i = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;

    // Reset state
    tick();
    tick();
    chk("rst_addr", int'(addr_o), 0);
    chk("rst_sequsr", int'(sequsr_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_pulses", int'({ok_o, err_o, tmo_o}), 0);
    r_i = 1'b1;
    tick();

    // Single-press table: round of one entry, one edge of a button pattern
    vt[0] = '{4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
    vt[3] = '{4'b1000, 2'd3, 1'b1, 1'b0, 1'b0};
    vt[4] = '{4'b0001, 2'd3, 1'b0, 1'b1, 1'b0};
    vt[5] = '{4'b1000, 2'd0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{4'b0011, 2'd0, 1'b0, 1'b0, 1'b1};
    vt[7] = '{4'b1111, 2'd3, 1'b0, 1'b0, 1'b1};
    vt[8] = '{4'b0000, 2'd1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      mem[0]  = vt[i].expc;
      round_i = 4'd0;
      e_i     = 1'b1;
      tick();
      btn_i = vt[i].btn;
      tick();
      chk($sformatf("vec%0d_ok", i), int'(ok_o), int'(vt[i].ok));
      chk($sformatf("vec%0d_err", i), int'(err_o), int'(vt[i].err));
      chk($sformatf("vec%0d_tmo", i), int'(tmo_o), 0);
      chk($sformatf("vec%0d_busy", i), int'(busy_o), int'(vt[i].busy));
      idle_out();
    end

    // Full round {0,3,1}
    mem[0] = 2'd0; mem[1] = 2'd3; mem[2] = 2'd1;
    tr_round = 2;
    set_entry(0, 2'd0, 2, 2); set_entry(1, 2'd3, 4, 2); set_entry(2, 2'd1, 4, 1);
    run_trial("full");
    chk("full_sequsr_const", int'(sequsr_o), 3);

    // Wrong colour on the second entry
    mem[0] = 2'd2; mem[1] = 2'd2; mem[2] = 2'd0; mem[3] = 2'd1;
    tr_round = 3;
    set_entry(0, 2'd2, 3, 1); set_entry(1, 2'd1, 3, 1);
    set_entry(2, 2'd0, 3, 1); set_entry(3, 2'd1, 3, 1);
    run_trial("wrong");
    chk("wrong_sequsr_const", int'(sequsr_o), 1);
    chk("wrong_addr_const", int'(addr_o), 1);

    // Timeout with no presses, then a press exactly at the last timer value
    tr_round = 0; mem[0] = 2'd2;
    set_entry(0, 2'd2, TMO + 1, 1);
    run_trial("timeout");
    tr_round = 0;
    set_entry(0, 2'd2, TMO, 1);
    run_trial("press_at_limit");
    chk("limit_sequsr_const", int'(sequsr_o), 1);

    // Held button counts once
    mem[0] = 2'd0; mem[1] = 2'd0;
    tr_round = 1;
    set_entry(0, 2'd0, 1, 10); set_entry(1, 2'd0, 12, 1);
    run_trial("held");
    chk("held_sequsr_const", int'(sequsr_o), 2);

    // Multi-hot then release: no press, no error; a later real press still counts
    mem[0] = 2'd0; round_i = 4'd0; e_i = 1'b1;
    tick();
    btn_i = 4'b0011; tick();
    chk("multi_pulse_a", int'({ok_o, err_o, tmo_o}), 0);
    tick();
    btn_i = 4'b0000; tick();
    chk("multi_pulse_b", int'({ok_o, err_o, tmo_o}), 0);
    chk("multi_busy", int'(busy_o), 1);
    tick();
    btn_i = 4'b0001; tick();
    chk("multi_then_ok", int'(ok_o), 1);
    idle_out();

    // Abort mid-round by dropping enable
    mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3; mem[3] = 2'd0;
    round_i = 4'd3; e_i = 1'b1;
    tick();
    btn_i = 4'b0010; tick();
    btn_i = 4'b0000; tick();
    e_i = 1'b0; tick();
    chk("abort_busy", int'(busy_o), 0);
    base = 0;
    for (int i = 0; i < 4; i++) begin
      if (ok_o || err_o || tmo_o) base++;
      tick();
    end
    chk("abort_no_pulse", base, 0);
    chk("abort_sequsr_hold", int'(sequsr_o), 1);

    // Asynchronous reset while waiting for release
    e_i = 1'b1; round_i = 4'd3;
    tick();
    btn_i = 4'b0010; tick();
    chk("pre_rst_addr", int'(addr_o), 1);
    #2 r_i = 1'b0;
    #1;
    chk("arst_addr", int'(addr_o), 0);
    chk("arst_sequsr", int'(sequsr_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_pulses", int'({ok_o, err_o, tmo_o}), 0);
    btn_i = 4'd0; e_i = 1'b0;
    tick();
    r_i = 1'b1;
    tick();

    // Boundary: 16-entry round
    tr_round = 15;
    for (int k = 0; k < 16; k++) begin
      mem[k] = 2'($urandom_range(0, 3));
      set_entry(k, mem[k], 2, 1);
    end
    run_trial("boundary");
    chk("bound_addr_const", int'(addr_o), 15);
    chk("bound_sequsr_const", int'(sequsr_o), 16);

    // Random rounds against the model
    for (int n = 0; n < 25; n++) begin
      tr_round = int'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
        mem[k]     = 2'($urandom_range(0, 3));
        tr_hold[k] = int'($urandom_range(1, 4));
        base       = (k == 0) ? 1 : tr_hold[k-1] + 1;
        tr_gap[k]  = base + int'($urandom_range(0, 20 - base));
        if ($urandom_range(0, 15) == 0) tr_gap[k] = int'($urandom_range(21, 24));
        tr_col[k]  = mem[k];
        if ($urandom_range(0, 19) == 0) tr_col[k] = mem[k] ^ 2'($urandom_range(1, 3));
      end
      run_trial($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
